// File: rtl/softmax_arbiter.sv
// softmax_arbiter: round-robin sharing of one softmax engine among R row producers.
// A grant covers a whole row: start pulse, N inputs forwarded, N outputs routed back.
module softmax_arbiter #(
  parameter int R     = 4,
  parameter int N     = 256,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  localparam int ID_W = $clog2(R)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [R-1:0]      req_i,
  output logic [R-1:0]      gnt_o,
  input  logic [R-1:0]      req_valid_i,
  input  logic [R*IN_W-1:0] req_data_i,
  output logic [R-1:0]      req_ready_o,
  output logic [R-1:0]      rsp_valid_o,
  output logic [OUT_W-1:0]  rsp_data_o,
  output logic              rsp_last_o,
  output logic [ID_W-1:0]   owner_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              sm_start_o,
  output logic              sm_in_valid_o,
  output logic [IN_W-1:0]   sm_in_data_o,
  input  logic              sm_in_ready_i,
  input  logic              sm_out_valid_i,
  input  logic [OUT_W-1:0]  sm_out_data_i,
  input  logic              sm_done_i
);

  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

  state_e             state_q, state_d;
  logic [R-1:0]       gnt_q, gnt_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               start_q, start_d;
  logic [R-1:0]       rsp_valid_q, rsp_valid_d;
  logic [OUT_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_last_q, rsp_last_d;
  logic               err_q, err_d;

  logic               load, active, in_acc, found;
  logic [ID_W-1:0]    win, rr_next;
  logic [ID_W:0]      idx;

  assign load   = (state_q == LOAD);
  assign active = (state_q != IDLE);

  assign sm_in_valid_o = req_valid_i[owner_q] & load;
  assign sm_in_data_o  = req_data_i[int'(owner_q)*IN_W +: IN_W];
  assign req_ready_o   = gnt_q & {R{sm_in_ready_i & load}};
  assign in_acc        = sm_in_valid_o & sm_in_ready_i;

  assign rr_next = (owner_q == ID_W'(R-1)) ? '0 : owner_q + 1'b1;

  // first requester at or above rr_q, wrapping
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < R; i++) begin
      idx = {1'b0, rr_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(R)) idx = idx - (ID_W+1)'(R);
      if (!found && req_i[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    start_d     = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = 1'b0;
    err_d       = err_q;

    if (in_acc && in_cnt_q != CNT_W'(N))
      in_cnt_d = in_cnt_q + 1'b1;

    if (sm_out_valid_i) begin
      if (active) begin
        rsp_valid_d = gnt_q;
        rsp_data_d  = sm_out_data_i;
        rsp_last_d  = (out_cnt_q == CNT_W'(N-1));
        if (out_cnt_q != CNT_W'(N))
          out_cnt_d = out_cnt_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (sm_done_i &&
        (state_q != RUN || out_cnt_q != CNT_W'(N-1)))
      err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = LOAD;
          gnt_d     = {{(R-1){1'b0}}, 1'b1} << win;
          owner_d   = win;
          start_d   = 1'b1;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      LOAD: begin
        // a premature done still ends the row so the engine is not stranded
        if (sm_done_i) begin
          state_d = IDLE;
          gnt_d   = '0;
          rr_d    = rr_next;
        end else if (in_acc && in_cnt_q == CNT_W'(N-1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (sm_done_i) begin
          state_d = IDLE;
          gnt_d   = '0;
          rr_d    = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_q        <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      err_q       <= err_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign owner_o     = owner_q;
  assign busy_o      = active;
  assign err_o       = err_q;
  assign sm_start_o  = start_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_last_o  = rsp_last_q;

endmodule

// File: tb/tb_softmax_arbiter.sv
// Bench for softmax_arbiter: stub engine, directed rows, queue scoreboard.
// Stub engine returns each accepted input XOR 16'h5A5A, in order.
module tb_softmax_arbiter;

  localparam int R = 4;
  localparam int N = 8;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [R-1:0]   req;
  logic [R-1:0]   gnt_o;
  logic [R-1:0]   req_valid;
  logic [R*W-1:0] req_data;
  logic [R-1:0]   req_ready_o;
  logic [R-1:0]   rsp_valid_o;
  logic [W-1:0]   rsp_data_o;
  logic           rsp_last_o;
  logic [1:0]     owner_o;
  logic           busy_o;
  logic           err_o;
  logic           sm_start_o;
  logic           sm_in_valid_o;
  logic [W-1:0]   sm_in_data_o;
  logic           sm_in_ready;
  logic           sm_out_valid;
  logic [W-1:0]   sm_out_data;
  logic           sm_done;

  softmax_arbiter #(.R(R), .N(N), .IN_W(W), .OUT_W(W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .gnt_o          (gnt_o),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_last_o     (rsp_last_o),
    .owner_o        (owner_o),
    .busy_o         (busy_o),
    .err_o          (err_o),
    .sm_start_o     (sm_start_o),
    .sm_in_valid_o  (sm_in_valid_o),
    .sm_in_data_o   (sm_in_data_o),
    .sm_in_ready_i  (sm_in_ready),
    .sm_out_valid_i (sm_out_valid),
    .sm_out_data_i  (sm_out_data),
    .sm_done_i      (sm_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [R-1:0] v;
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_after = N;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic logic [W-1:0] dat(input int b, input int k);
    return W'((b + k) << 7);
  endfunction

  // engine stub: samples mid-low-phase, drives 1 time unit after posedge
  initial begin
    int st, n_in, n_o;
    logic acc, stt;
    logic [W-1:0] dd;
    logic [W-1:0] mem [N];
    sm_in_ready  = 1'b0;
    sm_out_valid = 1'b0;
    sm_out_data  = '0;
    sm_done      = 1'b0;
    st = 0; n_in = 0; n_o = 0;
    forever begin
      @(negedge clk); #2;
      acc = sm_in_valid_o & sm_in_ready;
      stt = sm_start_o;
      dd  = sm_in_data_o;
      @(posedge clk); #1;
      if (!rst_n) begin
        st = 0;
        sm_in_ready  = 1'b0;
        sm_out_valid = 1'b0;
        sm_done      = 1'b0;
      end else begin
        case (st)
          0: if (stt) begin st = 1; n_in = 0; sm_in_ready = 1'b1; end
          1: if (acc) begin
            mem[n_in] = dd;
            n_in++;
            if (n_in == N) begin sm_in_ready = 1'b0; st = 2; n_o = 0; end
          end
          2: st = 3;
          default: begin
            if (n_o < done_after) begin
              sm_out_valid = 1'b1;
              sm_out_data  = mem[n_o] ^ 16'h5A5A;
              sm_done      = (n_o == done_after - 1);
              n_o++;
            end else begin
              sm_out_valid = 1'b0;
              sm_done      = 1'b0;
              st = 0;
            end
          end
        endcase
      end
    end
  end

  // monitor: pops one expectation per routed output
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("gnt_onehot", 32'($onehot0(gnt_o)), 1);
        if (rsp_valid_o != '0) begin
          if (q.size() == 0) begin
            chk("rsp_unexpected", rsp_valid_o, 0);
          end else begin
            e = q.pop_front();
            chk("rsp_valid", rsp_valid_o, e.v);
            chk("rsp_data", rsp_data_o, e.d);
            chk("rsp_last", rsp_last_o, e.l);
          end
        end
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_rsp_last", rsp_last_o, 0);
    chk("rst_start", sm_start_o, 0);
    chk("rst_in_valid", sm_in_valid_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
  endtask

  task automatic run_row(input int r, input int base, input int stall_at,
                         input bit noise, input int n_out, input bit gap,
                         input bit drop, input bit rst_mid);
    int w, k, cyc, stl, nz;
    exp_t e;
    nz = (r + 1) % R;
    w  = 0;
    do begin @(negedge clk); w++; end while (gnt_o == '0 && w < 50);
    chk("gnt", gnt_o, 32'(1 << r));
    if (gnt_o == '0) return;
    chk("owner", owner_o, r);
    chk("start", sm_start_o, 1);
    chk("busy", busy_o, 1);
    if (gap) chk("idle_gap", w, 1);
    if (drop) req = '0;
    for (int i = 0; i < n_out; i++) begin
      e.v = R'(1 << r);
      e.d = dat(base, i) ^ 16'h5A5A;
      e.l = (i == N - 1);
      q.push_back(e);
    end
    k = 0; cyc = 0; stl = 0;
    while (k < N && cyc < 100) begin
      if (k == stall_at && stl < 3) begin
        req_valid[r] = 1'b0;
        stl++;
      end else begin
        req_valid[r] = 1'b1;
        req_data[r*W +: W] = dat(base, k);
      end
      if (noise) begin
        req_valid[nz] = 1'b1;
        req_data[nz*W +: W] = 16'hDEAD;
      end
      #1;
      if (cyc == 1) chk("start_pulse", sm_start_o, 0);
      if (!req_valid[r]) chk("stall_in_valid", sm_in_valid_o, 0);
      if (noise) chk("nonowner_ready", req_ready_o[nz], 0);
      if (sm_in_valid_o && sm_in_ready) begin
        chk("in_data", sm_in_data_o, dat(base, k));
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    chk("in_count", k, N);
    if (rst_mid) begin
      repeat (4) @(negedge clk);
      #3 rst_n = 1'b0;
      #1 chk_reset_vals();
      q.delete();
      req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    w = 0;
    while (gnt_o != '0 && w < 100) begin @(negedge clk); w++; end
    chk("gnt_release", gnt_o, 0);
    chk("idle_busy", busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // single requester, scores 0..7, request dropped after grant
    req = 4'b0010;
    run_row(1, 0, -1, 0, N, 0, 1, 0);
    chk("err_after_row", err_o, 0);

    // rr pointer now 2: of {0,1,3}, requester 3 wins
    req = 4'b1011;
    run_row(3, 8, -1, 0, N, 0, 1, 0);

    // everyone requesting: 0,1,2,3,0 with one idle cycle between rows
    req = 4'b1111;
    run_row(0, 16, -1, 0, N, 1, 0, 0);
    run_row(1, 24, -1, 0, N, 1, 0, 0);
    run_row(2, 32, -1, 0, N, 1, 0, 0);
    run_row(3, 40, -1, 0, N, 1, 0, 0);
    run_row(0, 48, -1, 0, N, 1, 1, 0);

    // 3-cycle owner stall plus non-owner noise
    req = 4'b0100;
    run_row(2, 0, 3, 1, N, 0, 1, 0);

    // engine finishes after 5 outputs
    done_after = 5;
    req = 4'b0001;
    run_row(0, 4, -1, 0, 5, 0, 1, 0);
    done_after = N;
    chk("err_sticky_set", err_o, 1);
    req = 4'b0010;
    run_row(1, 2, -1, 0, N, 0, 1, 0);
    chk("err_sticky_hold", err_o, 1);

    // asynchronous reset mid-row, then fresh arbitration
    req = 4'b0100;
    run_row(2, 3, -1, 0, N, 0, 1, 1);
    req = 4'b1000;
    run_row(3, 5, -1, 0, N, 0, 1, 0);
    chk("err_after_reset", err_o, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
